// File: rtl/dds_seq_pkg.sv
// Shared definitions for the PWM channel sequencer: FSM state encoding and
// the default busy-acknowledge timeout.
package dds_seq_pkg;

  localparam int BUSY_TIMEOUT_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_LAUNCH    = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_GAP       = 3'd5
  } seq_state_e;

endpackage

// File: rtl/seq_ch_pick.sv
// Next-channel priority search: lowest set mask bit at or above the pointer.
module seq_ch_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_mask,
  input  logic [7:0]   i_ptr,
  output logic [7:0]   o_idx,
  output logic         o_found
);

  // Scan from the top down so the lowest qualifying index is written last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_mask[i] && (8'(i) >= i_ptr)) begin
        o_idx   = 8'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_ch_sequencer.sv
// Launches enabled PWM channels one at a time in index order, waits for each
// burst to finish, inserts a programmable idle gap, and repeats for a number
// of passes (or forever when the loop count is zero).
module pwm_ch_sequencer
  import dds_seq_pkg::*;
#(
  parameter int _NUM_CHANNELS = 3,
  parameter int _GAP_WIDTH    = 16,
  parameter int BUSY_TIMEOUT  = BUSY_TIMEOUT_DEF
) (
  input  logic                     clk_50M,
  input  logic                     rst_n,
  input  logic                     cfg_wr,
  input  logic [_NUM_CHANNELS-1:0] cfg_mask,
  input  logic [_GAP_WIDTH-1:0]    cfg_gap,
  input  logic [7:0]               cfg_loops,
  input  logic                     start,
  input  logic                     stop,
  input  logic [_NUM_CHANNELS-1:0] pwm_busy,
  input  logic [_NUM_CHANNELS-1:0] pwm_valid,
  output logic [_NUM_CHANNELS-1:0] pwm_en,
  output logic [7:0]               cur_ch,
  output logic                     seq_busy,
  output logic                     seq_done,
  output logic                     seq_abort,
  output logic                     err_timeout
);

  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

  seq_state_e r_state, w_state_nxt;

  logic [_NUM_CHANNELS-1:0] r_sh_mask, r_act_mask;
  logic [_GAP_WIDTH-1:0]    r_sh_gap, r_act_gap;
  logic [7:0]               r_sh_loops, r_act_loops;
  logic [7:0]               r_ptr, r_sel_ch, r_cur_ch, r_pass;
  logic [TMO_W-1:0]         r_tmo_cnt;
  logic [_GAP_WIDTH-1:0]    r_gap_cnt;
  logic [_NUM_CHANNELS-1:0] r_pwm_en;
  logic                     r_done, r_abort, r_tmo;

  logic [7:0]               w_ptr_nxt, w_sel_nxt, w_cur_nxt, w_pass_nxt, w_pass_inc;
  logic [TMO_W-1:0]         w_tmo_nxt;
  logic [_GAP_WIDTH-1:0]    w_gap_nxt;
  logic [_NUM_CHANNELS-1:0] w_en_nxt, w_sel_onehot;
  logic                     w_done_nxt, w_abort_nxt, w_tmo_pulse, w_ch_end, w_load_act;
  logic [7:0]               w_pick_idx;
  logic                     w_pick_found, w_busy_hit, w_valid_hit, w_tmo_last, w_gap_last;

  seq_ch_pick #(.N(_NUM_CHANNELS)) u_pick (
    .i_mask  (r_act_mask),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  // Only the launched channel's handshakes count: r_pwm_en is its one-hot.
  assign w_busy_hit   = |(pwm_busy & r_pwm_en);
  assign w_valid_hit  = |(pwm_valid & r_pwm_en);
  assign w_sel_onehot = _NUM_CHANNELS'(1) << r_sel_ch;
  assign w_pass_inc   = r_pass + 8'd1;
  assign w_tmo_last   = (r_tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1));
  assign w_gap_last   = (r_gap_cnt == r_act_gap - _GAP_WIDTH'(1));

  // State register.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and next-datapath decode; stop overrides everything else.
  always_comb begin
    w_state_nxt = r_state;
    w_load_act  = 1'b0;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel_ch;
    w_cur_nxt   = r_cur_ch;
    w_pass_nxt  = r_pass;
    w_tmo_nxt   = r_tmo_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_en_nxt    = r_pwm_en;
    w_done_nxt  = 1'b0;
    w_abort_nxt = 1'b0;
    w_tmo_pulse = 1'b0;
    w_ch_end    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_load_act = 1'b1;
          w_ptr_nxt  = '0;
          w_pass_nxt = '0;
          // An empty mask completes immediately instead of spinning in SELECT.
          if (r_sh_mask == '0) w_done_nxt  = 1'b1;
          else                 w_state_nxt = S_SELECT;
        end
      end
      S_SELECT: begin
        if (w_pick_found) begin
          w_sel_nxt   = w_pick_idx;
          w_state_nxt = S_LAUNCH;
        end else begin
          // Pass end: wrap and re-search from index 0 on the next cycle.
          w_ptr_nxt  = '0;
          w_pass_nxt = w_pass_inc;
          if (r_act_loops != 8'd0 && w_pass_inc == r_act_loops) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_LAUNCH: begin
        w_en_nxt    = w_sel_onehot;
        w_cur_nxt   = r_sel_ch;
        w_tmo_nxt   = '0;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (w_busy_hit) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (w_tmo_last) begin
          w_tmo_pulse = 1'b1;
          w_ch_end    = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (w_valid_hit) w_ch_end = 1'b1;
      end
      S_GAP: begin
        if (w_gap_last) w_state_nxt = S_SELECT;
        else            w_gap_nxt   = r_gap_cnt + _GAP_WIDTH'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_ch_end) begin
      w_en_nxt    = '0;
      w_ptr_nxt   = r_cur_ch + 8'd1;
      w_gap_nxt   = '0;
      w_state_nxt = (r_act_gap != '0) ? S_GAP : S_SELECT;
    end
    if (stop && r_state != S_IDLE) begin
      w_state_nxt = S_IDLE;
      w_en_nxt    = '0;
      w_abort_nxt = 1'b1;
      w_done_nxt  = 1'b0;
      w_tmo_pulse = 1'b0;
    end
  end

  // Config shadow/active registers, counters and registered outputs.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_mask   <= '0;
      r_sh_gap    <= '0;
      r_sh_loops  <= 8'd1;
      r_act_mask  <= '0;
      r_act_gap   <= '0;
      r_act_loops <= 8'd1;
      r_ptr       <= '0;
      r_sel_ch    <= '0;
      r_cur_ch    <= '0;
      r_pass      <= '0;
      r_tmo_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_pwm_en    <= '0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
      r_tmo       <= 1'b0;
    end else begin
      if (cfg_wr) begin
        r_sh_mask  <= cfg_mask;
        r_sh_gap   <= cfg_gap;
        r_sh_loops <= cfg_loops;
      end
      if (w_load_act) begin
        r_act_mask  <= r_sh_mask;
        r_act_gap   <= r_sh_gap;
        r_act_loops <= r_sh_loops;
      end
      r_ptr     <= w_ptr_nxt;
      r_sel_ch  <= w_sel_nxt;
      r_cur_ch  <= w_cur_nxt;
      r_pass    <= w_pass_nxt;
      r_tmo_cnt <= w_tmo_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_pwm_en  <= w_en_nxt;
      r_done    <= w_done_nxt;
      r_abort   <= w_abort_nxt;
      r_tmo     <= w_tmo_pulse;
    end
  end

  assign pwm_en      = r_pwm_en;
  assign cur_ch      = r_cur_ch;
  assign seq_busy    = (r_state != S_IDLE);
  assign seq_done    = r_done;
  assign seq_abort   = r_abort;
  assign err_timeout = r_tmo;

endmodule
